// File: rtl/icache_rd_bridge.sv
// icache_rd_bridge: turns single cache read requests into one AXI4 INCR read burst and returns the assembled line.
module icache_rd_bridge #(
    parameter logic [3:0] AXI_ID         = 4'h0,
    parameter logic [3:0] CACHED_ARCACHE = 4'b1111
) (
    input  logic         clk_g,
    input  logic         rst,
    input  logic         rd_req,
    input  logic         rd_uncache,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [127:0] ret_data,
    output logic         bus_err,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [3:0]   arcache,
    output logic         arvalid,
    input  logic         arready,
    input  logic [3:0]   rid,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);
    typedef enum logic [1:0] {IDLE, AR, R, RET} state_t;
    state_t      state;
    logic        unc;
    logic [31:3] addr_q;
    logic [1:0]  cnt;
    logic        err;
    logic [1:0]  lim;
    logic [1:0]  slot;
    logic        unused_ok;
    assign unused_ok = ^{rid, rd_addr[2:0]};
    assign lim       = unc ? 2'd1 : 2'd3;
    // uncached fetches land in the upper half of the line
    assign slot      = unc ? {1'b1, cnt[0]} : cnt;
    assign rd_rdy    = state == IDLE;
    assign arvalid   = state == AR;
    assign rready    = state == R;
    assign ret_valid = state == RET;
    assign bus_err   = ret_valid & err;
    assign arid      = AXI_ID;
    assign araddr    = unc ? {addr_q, 3'h0} : {addr_q[31:4], 4'h0};
    assign arlen     = unc ? 8'd1 : 8'd3;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arcache   = unc ? 4'b0000 : CACHED_ARCACHE;
    always_ff @(posedge clk_g) begin
        if (rst) begin
            state    <= IDLE;
            unc      <= 1'b0;
            addr_q   <= '0;
            cnt      <= 2'd0;
            err      <= 1'b0;
            ret_data <= '0;
        end else begin
            case (state)
                IDLE: if (rd_req) begin
                    state  <= AR;
                    unc    <= rd_uncache;
                    addr_q <= rd_addr[31:3];
                    cnt    <= 2'd0;
                    err    <= 1'b0;
                end
                AR: if (arready) state <= R;
                // extra beats without rlast keep overwriting the last slot
                R: if (rvalid) begin
                    ret_data[{slot, 5'b0} +: 32] <= rdata;
                    err   <= err | (rresp != 2'b00);
                    cnt   <= cnt == lim ? cnt : cnt + 2'd1;
                    state <= rlast ? RET : R;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_rd_bridge.sv
// tb_icache_rd_bridge: directed scenario checks for icache_rd_bridge.
module tb_icache_rd_bridge;
    logic         clk_g = 1'b0;
    logic         rst = 1'b1, rd_req = 1'b0, rd_uncache = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy, ret_valid, bus_err;
    logic [127:0] ret_data;
    logic [3:0]   arid, arcache;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, rready;
    logic         arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
    logic [3:0]   rid = '0;
    logic [31:0]  rdata = '0;
    logic [1:0]   rresp = '0;
    int tests = 0, fails = 0;

    always #5 clk_g = ~clk_g;

    icache_rd_bridge dut (
        .clk_g(clk_g), .rst(rst), .rd_req(rd_req), .rd_uncache(rd_uncache), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .bus_err(bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arcache(arcache), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    task automatic tick;
        @(posedge clk_g);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rvalid = 1'b1; rdata = d; rresp = resp; rlast = last; rid = 4'($urandom);
        tick;
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic issue(input logic unc, input logic [31:0] a);
        rd_req = 1'b1; rd_uncache = unc; rd_addr = a;
        tick;
        rd_req = 1'b0; arready = 1'b1;
        tick;
        arready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        tests++; if ({arvalid, rready, ret_valid, bus_err} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got %b want 0000", {arvalid, rready, ret_valid, bus_err}); end
        tests++; if (ret_data !== 128'h0) begin fails++; $display("FAIL reset_data got %h want 0", ret_data); end
        rst = 1'b0;
        tick;
        tests++; if (rd_rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy got %b want 1", rd_rdy); end
        tests++; if ({arvalid, rready, ret_valid, bus_err} !== 4'b0) begin fails++; $display("FAIL post_reset_ctrl got %b want 0000", {arvalid, rready, ret_valid, bus_err}); end
    endtask

    task automatic test_cached;
        rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h1FC0_0024;
        tests++; if (rd_rdy !== 1'b1) begin fails++; $display("FAIL cached_rdy got %b want 1", rd_rdy); end
        tick;
        rd_req = 1'b0;
        tests++; if ({arvalid, araddr, arlen, arcache, arsize, arburst, arid} !== {1'b1, 32'h1FC0_0020, 8'd3, 4'hF, 3'b010, 2'b01, 4'h0})
            begin fails++; $display("FAIL cached_ar got v=%b a=%h len=%0d c=%h sz=%b b=%b id=%h want v=1 a=1fc00020 len=3 c=f sz=010 b=01 id=0", arvalid, araddr, arlen, arcache, arsize, arburst, arid); end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        tests++; if ({arvalid, rready} !== 2'b01) begin fails++; $display("FAIL cached_r_state got %b want 01", {arvalid, rready}); end
        beat(32'h11111111, 2'b00, 1'b0);
        beat(32'h22222222, 2'b00, 1'b0);
        beat(32'h33333333, 2'b00, 1'b0);
        tests++; if (ret_valid !== 1'b0) begin fails++; $display("FAIL cached_early_ret got %b want 0", ret_valid); end
        beat(32'h44444444, 2'b00, 1'b1);
        tests++; if ({ret_valid, bus_err} !== 2'b10 || ret_data !== 128'h44444444_33333333_22222222_11111111)
            begin fails++; $display("FAIL cached_ret got v=%b e=%b d=%h want v=1 e=0 d=44444444333333332222222211111111", ret_valid, bus_err, ret_data); end
        tick;
        tests++; if ({ret_valid, rd_rdy} !== 2'b01) begin fails++; $display("FAIL cached_pulse got %b want 01", {ret_valid, rd_rdy}); end
    endtask

    task automatic test_uncached;
        rd_req = 1'b1; rd_uncache = 1'b1; rd_addr = 32'hBFC0_000C;
        tick;
        rd_req = 1'b0;
        tests++; if ({arvalid, araddr, arlen, arcache} !== {1'b1, 32'hBFC0_0008, 8'd1, 4'h0})
            begin fails++; $display("FAIL uncached_ar got v=%b a=%h len=%0d c=%h want v=1 a=bfc00008 len=1 c=0", arvalid, araddr, arlen, arcache); end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        beat(32'hAAAA0001, 2'b00, 1'b0);
        beat(32'hBBBB0002, 2'b00, 1'b1);
        tests++; if (ret_valid !== 1'b1 || ret_data !== {64'hBBBB0002_AAAA0001, 64'h22222222_11111111})
            begin fails++; $display("FAIL uncached_ret got v=%b d=%h want v=1 d=bbbb0002aaaa00012222222211111111", ret_valid, ret_data); end
        tick;
    endtask

    task automatic test_backpressure;
        rd_req = 1'b1; rd_uncache = 1'b0; rd_addr = 32'h0000_1234;
        tick;
        rd_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests++; if ({arvalid, araddr, arlen, arcache, rd_rdy} !== {1'b1, 32'h0000_1230, 8'd3, 4'hF, 1'b0})
                begin fails++; $display("FAIL bp_ar_hold%0d got v=%b a=%h len=%0d c=%h rdy=%b want v=1 a=00001230 len=3 c=f rdy=0", i, arvalid, araddr, arlen, arcache, rd_rdy); end
            tick;
        end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        beat(32'h01010101, 2'b00, 1'b0);
        tick;
        beat(32'h02020202, 2'b00, 1'b0);
        tick; tick;
        tests++; if ({rready, ret_valid, rd_rdy} !== 3'b100) begin fails++; $display("FAIL bp_gap got %b want 100", {rready, ret_valid, rd_rdy}); end
        beat(32'h03030303, 2'b00, 1'b0);
        tick;
        beat(32'h04040404, 2'b00, 1'b1);
        tests++; if (ret_valid !== 1'b1 || ret_data !== 128'h04040404_03030303_02020202_01010101)
            begin fails++; $display("FAIL bp_ret got v=%b d=%h want v=1 d=04040404030303030202020201010101", ret_valid, ret_data); end
        tick;
    endtask

    task automatic test_error;
        issue(1'b0, 32'h0000_0040);
        beat(32'hA0, 2'b00, 1'b0);
        beat(32'hA1, 2'b00, 1'b0);
        beat(32'hA2, 2'b10, 1'b0);
        beat(32'hA3, 2'b00, 1'b1);
        tests++; if ({ret_valid, bus_err} !== 2'b11) begin fails++; $display("FAIL err_pulse got %b want 11", {ret_valid, bus_err}); end
        tick;
        tests++; if (bus_err !== 1'b0) begin fails++; $display("FAIL err_clear got %b want 0", bus_err); end
        issue(1'b1, 32'h0000_0080);
        beat(32'hB0, 2'b00, 1'b0);
        beat(32'hB1, 2'b00, 1'b1);
        tests++; if ({ret_valid, bus_err} !== 2'b10) begin fails++; $display("FAIL err_clean got %b want 10", {ret_valid, bus_err}); end
        tick;
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 32'h0000_0500);
        beat(32'hC0, 2'b00, 1'b0);
        beat(32'hC1, 2'b00, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests++; if ({arvalid, rready, ret_valid, rd_rdy} !== 4'b0001) begin fails++; $display("FAIL rstmid_ctrl got %b want 0001", {arvalid, rready, ret_valid, rd_rdy}); end
        tick;
        tests++; if ({ret_valid, ret_data} !== {1'b0, 128'h0}) begin fails++; $display("FAIL rstmid_noret got v=%b d=%h want v=0 d=0", ret_valid, ret_data); end
        issue(1'b1, 32'h0000_0100);
        beat(32'h5, 2'b00, 1'b0);
        beat(32'h6, 2'b00, 1'b1);
        tests++; if (ret_valid !== 1'b1 || ret_data !== {32'h6, 32'h5, 64'h0})
            begin fails++; $display("FAIL rstmid_new got v=%b d=%h want v=1 d=00000006000000050000000000000000", ret_valid, ret_data); end
        tick;
    endtask

    task automatic test_back_to_back;
        rd_req = 1'b1; rd_uncache = 1'b1; rd_addr = 32'h0000_0200;
        tick;
        arready = 1'b1;
        tick;
        arready = 1'b0;
        beat(32'h11, 2'b00, 1'b0);
        beat(32'h22, 2'b00, 1'b1);
        tests++; if ({ret_valid, rd_rdy} !== 2'b10) begin fails++; $display("FAIL b2b_ret got %b want 10", {ret_valid, rd_rdy}); end
        rd_uncache = 1'b0; rd_addr = 32'h0000_0300;
        tick;
        tests++; if ({rd_rdy, ret_valid, arvalid} !== 3'b100) begin fails++; $display("FAIL b2b_accept got %b want 100", {rd_rdy, ret_valid, arvalid}); end
        tick;
        rd_req = 1'b0;
        tests++; if ({arvalid, araddr} !== {1'b1, 32'h0000_0300} || ret_data !== {32'h22, 32'h11, 64'h0})
            begin fails++; $display("FAIL b2b_hold_ar got v=%b a=%h d=%h want v=1 a=00000300 d=00000022000000110000000000000000", arvalid, araddr, ret_data); end
        arready = 1'b1;
        tick;
        arready = 1'b0;
        tests++; if (ret_data !== {32'h22, 32'h11, 64'h0}) begin fails++; $display("FAIL b2b_hold_r got %h want 00000022000000110000000000000000", ret_data); end
        beat(32'h33, 2'b00, 1'b0);
        tests++; if (ret_data !== {32'h22, 32'h11, 32'h0, 32'h33}) begin fails++; $display("FAIL b2b_first_beat got %h want 00000022000000110000000000000033", ret_data); end
        beat(32'h44, 2'b00, 1'b0);
        beat(32'h55, 2'b00, 1'b0);
        beat(32'h66, 2'b00, 1'b1);
        tests++; if (ret_valid !== 1'b1 || ret_data !== {32'h66, 32'h55, 32'h44, 32'h33})
            begin fails++; $display("FAIL b2b_second got v=%b d=%h want v=1 d=00000066000000550000004400000033", ret_valid, ret_data); end
        tick;
    endtask

    task automatic test_overrun;
        issue(1'b1, 32'h0000_0400);
        beat(32'hA, 2'b00, 1'b0);
        beat(32'hB, 2'b00, 1'b0);
        tests++; if ({rready, ret_valid} !== 2'b10) begin fails++; $display("FAIL ovr_wait got %b want 10", {rready, ret_valid}); end
        beat(32'hC, 2'b00, 1'b1);
        tests++; if (ret_valid !== 1'b1 || ret_data !== {32'hC, 32'hA, 32'h44, 32'h33})
            begin fails++; $display("FAIL ovr_ret got v=%b d=%h want v=1 d=0000000c0000000a0000004400000033", ret_valid, ret_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_cached;
        test_uncached;
        test_backpressure;
        test_error;
        test_reset_mid;
        test_back_to_back;
        test_overrun;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
